// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle between the two requesters, the arbiter and the RAM.
//   Requester 0/1 : reqN, cmdN, addrN, wdataN, lockN -> arbiter
//                   ackN, rdataN, gntN             <- arbiter
//   RAM side      : ram_addr, ram_cmd, ram_wdata   <- arbiter
//                   ram_rdata                      -> arbiter
//   Status        : busy                           <- arbiter
// slave  = arbiter view, master = environment view (requesters + RAM).
interface mem_arbiter_if #(
   parameter int AW = 9,
   parameter int DW = 16
);
   logic          req0;
   logic [1:0]    cmd0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          lock0;
   logic          ack0;
   logic [DW-1:0] rdata0;
   logic          gnt0;

   logic          req1;
   logic [1:0]    cmd1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          lock1;
   logic          ack1;
   logic [DW-1:0] rdata1;
   logic          gnt1;

   logic [AW-1:0] ram_addr;
   logic [1:0]    ram_cmd;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          busy;

   modport slave (
      input  req0, cmd0, addr0, wdata0, lock0,
      input  req1, cmd1, addr1, wdata1, lock1,
      input  ram_rdata,
      output ack0, rdata0, gnt0,
      output ack1, rdata1, gnt1,
      output ram_addr, ram_cmd, ram_wdata, busy
   );

   modport master (
      output req0, cmd0, addr0, wdata0, lock0,
      output req1, cmd1, addr1, wdata1, lock1,
      output ram_rdata,
      input  ack0, rdata0, gnt0,
      input  ack1, rdata1, gnt1,
      input  ram_addr, ram_cmd, ram_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one synchronous
// single-port RAM. Each access walks IDLE -> ISSUE -> WAIT -> ACK -> IDLE,
// so accesses never overlap and RAM read data is always captured in WAIT.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (requester handshakes, RAM bus, busy)
module mem_arbiter #(
   parameter int         AW     = 9,
   parameter int         DW     = 16,
   parameter logic [1:0] MNONE  = 2'b00,
   parameter logic [1:0] MREAD  = 2'b01,
   parameter logic [1:0] MWRITE = 2'b10
) (
   input  logic           clk,
   input  logic           reset,
   mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          grant_go;
   logic          win_nxt;
   logic          win_lock;

   // Access context captured when leaving IDLE; requester inputs are not
   // looked at again until the FSM is back in IDLE.
   logic          lat_win;
   logic [1:0]    lat_cmd;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;

   logic          last_grant;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   // Only read and write reach the RAM; anything else becomes a no-op
   // access that is still granted and acknowledged.
   function automatic logic [1:0] ram_cmd_of(input logic [1:0] cmd);
      if (cmd == MREAD || cmd == MWRITE) begin
         return cmd;
      end
      return MNONE;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_go  = 1'b0;
      win_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant_go  = 1'b1;
               state_nxt = ISSUE;
               // On a tie the port that did not win last time gets it.
               if (bus.req0 && bus.req1) begin
                  win_nxt = ~last_grant;
               end else begin
                  win_nxt = bus.req1;
               end
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign win_lock = win_nxt ? bus.lock1 : bus.lock0;

   // Access context: pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (grant_go) begin
         lat_win   <= win_nxt;
         lat_cmd   <= win_nxt ? bus.cmd1   : bus.cmd0;
         lat_addr  <= win_nxt ? bus.addr1  : bus.addr0;
         lat_wdata <= win_nxt ? bus.wdata1 : bus.wdata0;
      end
   end

   // A locked winner records the other port as last grant so that it
   // wins the next tie again.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (grant_go) begin
         last_grant <= win_lock ? ~win_nxt : win_nxt;
      end
   end

   // Read data arrives during WAIT; each port keeps its own copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state == WAIT && lat_cmd == MREAD) begin
         if (lat_win) begin
            rdata1_q <= bus.ram_rdata;
         end else begin
            rdata0_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.gnt0      = (state != IDLE) && !lat_win;
   assign bus.gnt1      = (state != IDLE) &&  lat_win;
   assign bus.ack0      = (state == ACK)  && !lat_win;
   assign bus.ack1      = (state == ACK)  &&  lat_win;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.ram_cmd   = (state == ISSUE) ? ram_cmd_of(lat_cmd) : MNONE;
   assign bus.ram_addr  = (state == ISSUE) ? lat_addr  : '0;
   assign bus.ram_wdata = (state == ISSUE) ? lat_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a RAM device model,
// a transaction-level reference model and a per-cycle compare process.
module tb_mem_arbiter;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(9), .DW(16)) bus ();

   mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // Bench-side preload/clear control shared by RAM device and model.
   logic        clr = 1'b0;
   logic        pl_en = 1'b0;
   logic [8:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;
   logic        chk_en = 1'b0;

   // ---------------- RAM device ----------------
   logic [15:0] ram_mem [512];
   initial begin
      bus.ram_rdata = '0;
      forever begin
         @(posedge clk);
         if (clr) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= '0;
         end
         if (pl_en) ram_mem[pl_addr] <= pl_data;
         if (bus.ram_cmd == MWRITE) ram_mem[bus.ram_addr] <= bus.ram_wdata;
         if (bus.ram_cmd == MREAD)  bus.ram_rdata <= ram_mem[bus.ram_addr];
      end
   end

   // ---------------- reference model ----------------
   // One access = grant at an IDLE edge, then 3 busy cycles (left = 3,2,1);
   // the memory effect is atomic at grant because accesses never overlap.
   logic [15:0] mdl_mem [512];
   int          m_left = 0;
   logic        m_w = 1'b0;
   logic [1:0]  m_cmd = MNONE;
   logic [8:0]  m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] m_val = '0;
   logic [15:0] m_rd0 = '0;
   logic [15:0] m_rd1 = '0;
   logic        m_last = 1'b1;

   initial begin
      forever begin
         @(posedge clk);
         if (clr) begin
            for (int i = 0; i < 512; i++) mdl_mem[i] = '0;
         end
         if (pl_en) mdl_mem[pl_addr] = pl_data;
         if (reset) begin
            m_left = 0;
            m_last = 1'b1;
            m_rd0  = '0;
            m_rd1  = '0;
         end else if (m_left == 0) begin
            if (bus.req0 || bus.req1) begin
               m_w     = (bus.req0 && bus.req1) ? !m_last : bus.req1;
               m_cmd   = m_w ? bus.cmd1   : bus.cmd0;
               m_addr  = m_w ? bus.addr1  : bus.addr0;
               m_wdata = m_w ? bus.wdata1 : bus.wdata0;
               m_last  = (m_w ? bus.lock1 : bus.lock0) ? !m_w : m_w;
               m_left  = 3;
               if (m_cmd == MWRITE) mdl_mem[m_addr] = m_wdata;
               if (m_cmd == MREAD)  m_val = mdl_mem[m_addr];
            end
         end else begin
            if (m_left == 2 && m_cmd == MREAD) begin
               if (m_w) m_rd1 = m_val;
               else     m_rd0 = m_val;
            end
            m_left = m_left - 1;
         end
      end
   end

   // ---------------- compare + monitors ----------------
   int cyc = 0;
   int gq [$];
   int ack_t [$];
   int ack0_cnt = 0;
   int ack1_cnt = 0;
   int rdcmd_cnt = 0;
   int nzcmd_cnt = 0;
   logic pg0 = 1'b0;
   logic pg1 = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            logic [1:0] e_cmd;
            e_cmd = MNONE;
            if (m_left == 3 && (m_cmd == MREAD || m_cmd == MWRITE)) e_cmd = m_cmd;
            check("busy",   32'(bus.busy),   32'(m_left != 0));
            check("gnt0",   32'(bus.gnt0),   32'(m_left != 0 && !m_w));
            check("gnt1",   32'(bus.gnt1),   32'(m_left != 0 &&  m_w));
            check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            check("ack0",   32'(bus.ack0),   32'(m_left == 1 && !m_w));
            check("ack1",   32'(bus.ack1),   32'(m_left == 1 &&  m_w));
            check("rdata0", 32'(bus.rdata0), 32'(m_rd0));
            check("rdata1", 32'(bus.rdata1), 32'(m_rd1));
            check("ram_cmd", 32'(bus.ram_cmd), 32'(e_cmd));
            if (e_cmd != MNONE) check("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
            if (e_cmd == MWRITE) check("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
            if (bus.gnt0 && !pg0) gq.push_back(0);
            if (bus.gnt1 && !pg1) gq.push_back(1);
            if (bus.ack0 || bus.ack1) ack_t.push_back(cyc);
            if (bus.ack0) ack0_cnt++;
            if (bus.ack1) ack1_cnt++;
            if (bus.ram_cmd == MREAD) rdcmd_cnt++;
            if (bus.ram_cmd != MNONE) nzcmd_cnt++;
         end
         pg0 = bus.gnt0;
         pg1 = bus.gnt1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [8:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic rq(input int p, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] d, input logic lk);
      if (p == 0) begin
         bus.req0 = 1'b1; bus.cmd0 = c; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
      end else begin
         bus.req1 = 1'b1; bus.cmd1 = c; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
      end
   endtask

   task automatic drop_all();
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
   endtask

   // Returns number of negedges seen up to and including the ack cycle.
   task automatic wait_ack(input int p, input int bound, output int n);
      bit got;
      got = 1'b0;
      n = 0;
      while (!got && n < bound) begin
         @(negedge clk);
         n++;
         if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) got = 1'b1;
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_grants(input int target, input int bound);
      int n;
      n = 0;
      while (gq.size() < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (gq.size() < target) check("grant_timeout", 32'(gq.size()), 32'(target));
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < bound);
      if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n, base, abase, rbase, a0base, a1base, nzbase;
      drop_all();
      bus.cmd0 = MNONE; bus.addr0 = '0; bus.wdata0 = '0;
      bus.cmd1 = MNONE; bus.addr1 = '0; bus.wdata1 = '0;
      reset = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      preload(9'h005, 16'h1234);
      preload(9'h010, 16'hA5A5);
      preload(9'h020, 16'h7777);
      reset = 1'b0;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_busy",   32'(bus.busy), 32'd0);
      check("rst_gnt",    32'({bus.gnt0, bus.gnt1}), 32'd0);
      check("rst_ack",    32'({bus.ack0, bus.ack1}), 32'd0);
      check("rst_ramcmd", 32'(bus.ram_cmd), 32'd0);
      check("rst_ramaddr", 32'(bus.ram_addr), 32'd0);
      check("rst_rdata0", 32'(bus.rdata0), 32'd0);
      check("rst_rdata1", 32'(bus.rdata1), 32'd0);
      tick();

      // Single read of 0x005 by port 0. Count includes the IDLE cycle in
      // which req0 is first presented, so ACK is the 4th negedge.
      rbase = rdcmd_cnt; a1base = ack1_cnt;
      rq(0, MREAD, 9'h005, 16'h0000, 1'b0);
      wait_ack(0, 10, n);
      check("t1_latency", 32'(n), 32'd4);
      tick();
      drop_all();
      @(negedge clk);
      check("t1_rdata0", 32'(bus.rdata0), 32'h1234);
      check("t1_rdcmd_cycles", 32'(rdcmd_cnt - rbase), 32'd1);
      check("t1_no_ack1", 32'(ack1_cnt - a1base), 32'd0);
      tick();

      // Port 1 writes 0x1FF, port 0 reads it straight back.
      rq(1, MWRITE, 9'h1FF, 16'hBEEF, 1'b0);
      wait_ack(1, 10, n);
      tick();
      drop_all();
      rq(0, MREAD, 9'h1FF, 16'h0000, 1'b0);
      wait_ack(0, 10, n);
      check("t2_rdata0", 32'(bus.rdata0), 32'hBEEF);
      check("t2_rdata1", 32'(bus.rdata1), 32'h0000);
      check("t2_ram", 32'(ram_mem[9'h1FF]), 32'hBEEF);
      tick();
      drop_all();
      wait_idle(10);

      // Contention after reset: first tie to port 0, then alternate.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      base = gq.size(); abase = ack_t.size();
      rq(0, MREAD, 9'h005, 16'h0000, 1'b0);
      rq(1, MREAD, 9'h010, 16'h0000, 1'b0);
      wait_grants(base + 4, 40);
      drop_all();
      wait_idle(10);
      if (gq.size() >= base + 4) begin
         check("t3_g0", 32'(gq[base]),     32'd0);
         check("t3_g1", 32'(gq[base + 1]), 32'd1);
         check("t3_g2", 32'(gq[base + 2]), 32'd0);
         check("t3_g3", 32'(gq[base + 3]), 32'd1);
      end
      if (ack_t.size() >= abase + 4) begin
         for (int i = 0; i < 3; i++)
            check("t3_ack_spacing", 32'(ack_t[abase + i + 1] - ack_t[abase + i]), 32'd4);
      end else begin
         check("t3_ack_count", 32'(ack_t.size() - abase), 32'd4);
      end

      // Lock: port 0 keeps winning. After lock0 drops the last grant still
      // recorded port 1, so the next tie is port 0 and the one after is port 1.
      base = gq.size();
      rq(0, MREAD, 9'h005, 16'h0000, 1'b1);
      rq(1, MREAD, 9'h010, 16'h0000, 1'b0);
      wait_grants(base + 3, 40);
      bus.lock0 = 1'b0;
      wait_grants(base + 5, 40);
      drop_all();
      wait_idle(10);
      if (gq.size() >= base + 5) begin
         check("t4_l0", 32'(gq[base]),     32'd0);
         check("t4_l1", 32'(gq[base + 1]), 32'd0);
         check("t4_l2", 32'(gq[base + 2]), 32'd0);
         check("t4_u0", 32'(gq[base + 3]), 32'd0);
         check("t4_u1", 32'(gq[base + 4]), 32'd1);
      end

      // Illegal command on port 1: acked, RAM untouched, rdata1 kept.
      nzbase = nzcmd_cnt; a1base = ack1_cnt;
      rq(1, 2'b11, 9'h007, 16'h5555, 1'b0);
      wait_ack(1, 10, n);
      tick();
      drop_all();
      wait_idle(10);
      check("t5_ramcmd_quiet", 32'(nzcmd_cnt - nzbase), 32'd0);
      check("t5_ack1", 32'(ack1_cnt - a1base), 32'd1);
      check("t5_rdata1", 32'(bus.rdata1), 32'hA5A5);

      // Reset during WAIT of a port 0 read.
      a0base = ack0_cnt;
      rq(0, MREAD, 9'h020, 16'h0000, 1'b0);
      tick();            // grant edge passed -> ISSUE
      tick();            // -> WAIT
      reset = 1'b1;
      drop_all();
      tick();            // reset sampled -> IDLE
      reset = 1'b0;
      @(negedge clk);
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_rdata0", 32'(bus.rdata0), 32'd0);
      repeat (4) tick();
      check("t6_no_ack0", 32'(ack0_cnt - a0base), 32'd0);
      base = gq.size();
      rq(0, MREAD, 9'h020, 16'h0000, 1'b0);
      rq(1, MREAD, 9'h010, 16'h0000, 1'b0);
      wait_grants(base + 1, 10);
      drop_all();
      wait_idle(10);
      if (gq.size() >= base + 1) check("t6_first_tie", 32'(gq[base]), 32'd0);
      check("t6_rdata0_after", 32'(bus.rdata0), 32'h7777);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t: got running want finished", $time);
      $fatal(1);
   end

endmodule
